lcd_spi: RTL and testbench
==========================

LCD_SPI -- requirements
Module: lcd_spi

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per transfer, SHALL be >= 1.
REQ-002 Parameter SPI_CLK_PERIOD, default 16: SCLK period in clock cycles, SHALL be even and >= 2.
REQ-003 clock  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data_i  input  DATA_WIDTH  word to transmit, sampled only at transfer start.
REQ-006 push_i  input  1  transfer request, level-sensitive; requester holds it high until done_o.
REQ-007 done_o  output  1  one-cycle pulse marking transfer completion.
REQ-008 spi_clk_o  output  1  SPI serial clock (SCLK).
REQ-009 spi_dat_o  output  1  SPI serial data (MOSI).

Function
REQ-010 States SHALL be IDLE, SHIFT and DONE.
REQ-011 In IDLE with push_i=1 at a rising edge, data_i SHALL be loaded into a shift register and the state SHALL move to SHIFT.
- In IDLE with push_i=0, the state SHALL remain IDLE.
REQ-012 SPI mode 0: SCLK idles low; data changes while SCLK is low; the receiver samples on the SCLK rising edge.
REQ-013 Each bit SHALL occupy SPI_CLK_PERIOD cycles:
- spi_clk_o low for SPI_CLK_PERIOD/2 cycles, then high for SPI_CLK_PERIOD/2 cycles.
REQ-014 Bits SHALL be sent MSB first.
- spi_dat_o SHALL show bit DATA_WIDTH-1 from the first SHIFT cycle.
- Each subsequent bit SHALL appear on the edge where spi_clk_o returns low.
REQ-015 Exactly DATA_WIDTH SCLK rising edges SHALL occur per transfer.
REQ-016 After the last bit's high phase, spi_clk_o SHALL return low and the state SHALL move to DONE.
- Entry to DONE SHALL occur DATA_WIDTH*SPI_CLK_PERIOD cycles after the accepting edge.
REQ-017 done_o SHALL be registered, high only in the DONE state, and high for exactly one cycle.
- DONE SHALL always return to IDLE on the next edge, regardless of push_i.
REQ-018 A requester that drops push_i on the edge that samples done_o=1 SHALL NOT trigger a second transfer.
- A new push_i in the following cycle SHALL start the next transfer (back-to-back allowed).
REQ-019 Changes on data_i or push_i during SHIFT SHALL be ignored.
REQ-020 In IDLE and DONE, spi_clk_o SHALL be 0 and spi_dat_o SHALL be 0.
REQ-021 The bit counter SHALL be ceil(log2(DATA_WIDTH+1)) bits wide.
- The half-period divider counter SHALL be ceil(log2(SPI_CLK_PERIOD/2+1)) bits wide.
- Neither counter SHALL wrap within a transfer.

Reset
REQ-022 Asserting reset (low) SHALL immediately force:
- state IDLE
- done_o=0, spi_clk_o=0, spi_dat_o=0
- counters and shift register cleared.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer with no done_o pulse.
- After release, the block SHALL wait in IDLE for push_i.

Structure
REQ-024 No shared package is required; the state enum and counter widths SHALL be local to lcd_spi.
REQ-025 An optional sub-module lcd_spi_clkdiv (half-period tick generator, enabled only in SHIFT) is permitted; otherwise lcd_spi is a single module.

Verification
REQ-026 DATA_WIDTH=8, SPI_CLK_PERIOD=16, push_i=1 with data_i=8'hA5:
- 8 SCLK rising edges sample 1,0,1,0,0,1,0,1;
- each SCLK high phase lasts 8 cycles;
- done_o pulses once, 128 cycles after acceptance.
REQ-027 Repeated push/done handshake with random data for 1000 cycles:
- each transfer SHALL be captured correctly (decoded word == pushed word);
- no extra transfer SHALL occur after a done_o pulse;
- the next transfer SHALL start one cycle after push_i re-asserts.
REQ-028 push_i held low for 50 cycles after reset -> spi_clk_o=0, spi_dat_o=0, done_o=0 throughout.
REQ-029 data_i toggled mid-transfer of 8'h3C -> shifted word remains 8'h3C.
REQ-030 reset asserted after 4 bits -> outputs 0 immediately, no done_o pulse; the next push of 8'hFF transmits correctly.
REQ-031 SPI_CLK_PERIOD=2, DATA_WIDTH=16, word 16'h8001 -> 1-cycle SCLK phases, 16 edges, done_o 32 cycles after acceptance.

Source files
------------

// File: rtl/lcd_spi_clkdiv.sv
// Half-period tick generator for the SPI serial clock.
// Counts only while enabled and restarts from zero whenever it is disabled.
module lcd_spi_clkdiv #(
   parameter int HALF = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic en,
   output logic tick
);
   localparam int CW = $clog2(HALF + 1);
   localparam logic [CW-1:0] LAST = CW'(HALF - 1);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else if (!en || cnt_reg == LAST) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign tick = en && (cnt_reg == LAST);
endmodule

// File: rtl/lcd_spi.sv
// Write-only SPI mode-0 transmitter for an LCD: MSB first, one word per push/done handshake.
// All outputs are registered; SCLK phases are timed by lcd_spi_clkdiv.
module lcd_spi #(
   parameter int DATA_WIDTH     = 8,
   parameter int SPI_CLK_PERIOD = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic                  done_o,
   output logic                  spi_clk_o,
   output logic                  spi_dat_o
);
   localparam int HALF = SPI_CLK_PERIOD / 2;
   localparam int BW   = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                state_reg;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] shift_next;
   logic [BW-1:0]         bit_cnt_reg;
   logic                  tick;

   assign shift_next = shift_reg << 1;

   lcd_spi_clkdiv #(
      .HALF (HALF)
   ) u_clkdiv (
      .clock (clock),
      .reset (reset),
      .en    (state_reg == SHIFT),
      .tick  (tick)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         done_o      <= 1'b0;
         spi_clk_o   <= 1'b0;
         spi_dat_o   <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (push_i) begin
                  shift_reg   <= data_i;
                  bit_cnt_reg <= '0;
                  spi_dat_o   <= data_i[DATA_WIDTH-1];
                  state_reg   <= SHIFT;
               end
            end
            SHIFT: begin
               if (tick) begin
                  if (!spi_clk_o) begin
                     spi_clk_o <= 1'b1;
                  end else begin
                     // Falling edge: either present the next bit or finish.
                     spi_clk_o <= 1'b0;
                     if (bit_cnt_reg == LAST_BIT) begin
                        state_reg   <= DONE;
                        done_o      <= 1'b1;
                        spi_dat_o   <= 1'b0;
                        shift_reg   <= '0;
                        bit_cnt_reg <= '0;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        shift_reg   <= shift_next;
                        spi_dat_o   <= shift_next[DATA_WIDTH-1];
                     end
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_spi.sv
// Directed bench for lcd_spi: an 8-bit/16-cycle instance and a 16-bit/2-cycle instance.
module tb_lcd_spi;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  data_a = '0;
   logic        push_a = 1'b0;
   logic        done_a, sclk_a, sdat_a;
   logic [15:0] data_b = '0;
   logic        push_b = 1'b0;
   logic        done_b, sclk_b, sdat_b;
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   lcd_spi #(.DATA_WIDTH(8), .SPI_CLK_PERIOD(16)) dut_a (
      .clock (clk), .reset (rst_n), .data_i (data_a), .push_i (push_a),
      .done_o (done_a), .spi_clk_o (sclk_a), .spi_dat_o (sdat_a)
   );

   lcd_spi #(.DATA_WIDTH(16), .SPI_CLK_PERIOD(2)) dut_b (
      .clock (clk), .reset (rst_n), .data_i (data_b), .push_i (push_b),
      .done_o (done_b), .spi_clk_o (sclk_b), .spi_dat_o (sdat_b)
   );

   // Drives one transfer on instance A from a negedge and decodes the serial stream.
   // Returns at the negedge where done_o is seen, with push_i already dropped.
   task automatic run_xfer_a(input logic [7:0] d, input bit toggle,
                             output logic [7:0] word, output int done_cyc,
                             output int edges, output int hi_min, output int hi_max,
                             output logic first_bit);
      int   hi;
      logic prev;
      data_a = d;
      push_a = 1'b1;
      @(posedge clk);
      word = '0; edges = 0; done_cyc = -1; hi_min = 999; hi_max = 0; hi = 0;
      prev = 1'b0; first_bit = 1'bx;
      for (int c = 0; c <= 300; c++) begin
         @(negedge clk);
         if (c == 0) first_bit = sdat_a;
         if (sclk_a && !prev) begin
            word = {word[6:0], sdat_a};
            edges++;
         end
         if (sclk_a) hi++;
         if (!sclk_a && prev) begin
            if (hi < hi_min) hi_min = hi;
            if (hi > hi_max) hi_max = hi;
            hi = 0;
         end
         prev = sclk_a;
         if (toggle) data_a = ~data_a;
         if (done_a) begin
            done_cyc = c;
            push_a = 1'b0;
            break;
         end
      end
      push_a = 1'b0;
      $display("xfer A data=%h word=%h edges=%0d done_at=%0d", d, word, edges, done_cyc);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if ({done_a, sclk_a, sdat_a} !== 3'b000) begin
         n_fail++; $display("FAIL reset_a: got %b expected 000", {done_a, sclk_a, sdat_a});
      end
      n_cmp++; if ({done_b, sclk_b, sdat_b} !== 3'b000) begin
         n_fail++; $display("FAIL reset_b: got %b expected 000", {done_b, sclk_b, sdat_b});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({done_a, sclk_a, sdat_a, done_b, sclk_b, sdat_b} !== 6'b0) begin
            n_fail++;
            $display("FAIL idle cycle %0d: got %b expected 000000", i,
                     {done_a, sclk_a, sdat_a, done_b, sclk_b, sdat_b});
         end
      end
   endtask

   task automatic check_quiet_a(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({done_a, sclk_a, sdat_a} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s quiet cycle %0d: got %b expected 000", tag, i, {done_a, sclk_a, sdat_a});
         end
      end
   endtask

   task automatic test_a5();
      logic [7:0] w; int dc, ed, hmin, hmax; logic fb;
      @(negedge clk);
      run_xfer_a(8'hA5, 1'b0, w, dc, ed, hmin, hmax, fb);
      n_cmp++; if (fb !== 1'b1) begin n_fail++; $display("FAIL a5_first_bit: got %b expected 1", fb); end
      n_cmp++; if (w !== 8'hA5) begin n_fail++; $display("FAIL a5_word: got %h expected a5", w); end
      n_cmp++; if (ed !== 8) begin n_fail++; $display("FAIL a5_edges: got %0d expected 8", ed); end
      n_cmp++; if (hmin !== 8) begin n_fail++; $display("FAIL a5_high_min: got %0d expected 8", hmin); end
      n_cmp++; if (hmax !== 8) begin n_fail++; $display("FAIL a5_high_max: got %0d expected 8", hmax); end
      n_cmp++; if (dc !== 128) begin n_fail++; $display("FAIL a5_done_cycle: got %0d expected 128", dc); end
      check_quiet_a("a5_after_done", 20);
   endtask

   task automatic test_data_toggle();
      logic [7:0] w; int dc, ed, hmin, hmax; logic fb;
      @(negedge clk);
      run_xfer_a(8'h3C, 1'b1, w, dc, ed, hmin, hmax, fb);
      n_cmp++; if (w !== 8'h3C) begin n_fail++; $display("FAIL toggle_word: got %h expected 3c", w); end
      n_cmp++; if (dc !== 128) begin n_fail++; $display("FAIL toggle_done_cycle: got %0d expected 128", dc); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w, d; int dc, ed, hmin, hmax; logic fb;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom);
         run_xfer_a(d, 1'b0, w, dc, ed, hmin, hmax, fb);
         n_cmp++; if (w !== d) begin n_fail++; $display("FAIL b2b_word[%0d]: got %h expected %h", i, w, d); end
         // Accepted on the edge right after re-assertion, so done lands exactly 128 cycles later.
         n_cmp++; if (dc !== 128) begin n_fail++; $display("FAIL b2b_done_cycle[%0d]: got %0d expected 128", i, dc); end
         @(negedge clk);
      end
      check_quiet_a("b2b_after_last", 10);
   endtask

   task automatic test_reset_mid();
      logic [7:0] w; int dc, ed, hmin, hmax; logic fb;
      data_a = 8'hFF;
      push_a = 1'b1;
      @(posedge clk);
      repeat (77) @(negedge clk);
      n_cmp++; if ({sclk_a, sdat_a} !== 2'b11) begin
         n_fail++; $display("FAIL mid_before_reset: got %b expected 11", {sclk_a, sdat_a});
      end
      #1 rst_n = 1'b0;
      push_a = 1'b0;
      #1;
      n_cmp++; if ({done_a, sclk_a, sdat_a} !== 3'b000) begin
         n_fail++; $display("FAIL mid_reset_immediate: got %b expected 000", {done_a, sclk_a, sdat_a});
      end
      check_quiet_a("mid_in_reset", 3);
      rst_n = 1'b1;
      check_quiet_a("mid_after_release", 150);
      run_xfer_a(8'hFF, 1'b0, w, dc, ed, hmin, hmax, fb);
      n_cmp++; if (w !== 8'hFF) begin n_fail++; $display("FAIL mid_next_word: got %h expected ff", w); end
      n_cmp++; if (ed !== 8) begin n_fail++; $display("FAIL mid_next_edges: got %0d expected 8", ed); end
      n_cmp++; if (dc !== 128) begin n_fail++; $display("FAIL mid_next_done_cycle: got %0d expected 128", dc); end
   endtask

   task automatic test_fast();
      logic [15:0] w; int dc, ed, hmin, hmax, hi; logic prev;
      @(negedge clk);
      data_b = 16'h8001;
      push_b = 1'b1;
      @(posedge clk);
      w = '0; dc = -1; ed = 0; hmin = 999; hmax = 0; hi = 0; prev = 1'b0;
      for (int c = 0; c <= 100; c++) begin
         @(negedge clk);
         if (sclk_b && !prev) begin w = {w[14:0], sdat_b}; ed++; end
         if (sclk_b) hi++;
         if (!sclk_b && prev) begin
            if (hi < hmin) hmin = hi;
            if (hi > hmax) hmax = hi;
            hi = 0;
         end
         prev = sclk_b;
         if (done_b) begin dc = c; push_b = 1'b0; break; end
      end
      push_b = 1'b0;
      $display("xfer B data=%h word=%h edges=%0d done_at=%0d", 16'h8001, w, ed, dc);
      n_cmp++; if (w !== 16'h8001) begin n_fail++; $display("FAIL fast_word: got %h expected 8001", w); end
      n_cmp++; if (ed !== 16) begin n_fail++; $display("FAIL fast_edges: got %0d expected 16", ed); end
      n_cmp++; if (hmin !== 1) begin n_fail++; $display("FAIL fast_high_min: got %0d expected 1", hmin); end
      n_cmp++; if (hmax !== 1) begin n_fail++; $display("FAIL fast_high_max: got %0d expected 1", hmax); end
      n_cmp++; if (dc !== 32) begin n_fail++; $display("FAIL fast_done_cycle: got %0d expected 32", dc); end
      @(negedge clk);
      n_cmp++; if ({done_b, sclk_b, sdat_b} !== 3'b000) begin
         n_fail++; $display("FAIL fast_after_done: got %b expected 000", {done_b, sclk_b, sdat_b});
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_a5();
      test_data_toggle();
      test_back_to_back();
      test_reset_mid();
      test_fast();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
